// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
//   Change dispenser sequencer. A Start in IDLE latches Cost/Paid, CHECK
//   classifies the payment, DISPENSE pays the change out one coin per
//   CoinValid/CoinReady handshake using a greedy quarter/dime/nickel choice
//   against the live coin box inventory, and FINISH pulses Done.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   Start, Cost, Paid             transaction request and operands (nickels)
//   LoadCoins, Load*              restock strobe and counts (IDLE only)
//   CoinReady / CoinValid,CoinOut coin ejector handshake, coin value in nickels
//   Quarters, Dimes, Nickels      live inventory
//   Remaining                     change still owed (nickels)
//   Busy, Done                    not-IDLE indicator, one-cycle end pulse
//   ExactAmmount, CoughUpMore,
//   NotEnoughChange               transaction status flags
module change_dispense_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       Start,
   input  logic [3:0] Cost,
   input  logic [3:0] Paid,
   input  logic       LoadCoins,
   input  logic [1:0] LoadQuarters,
   input  logic [1:0] LoadDimes,
   input  logic [1:0] LoadNickels,
   input  logic       CoinReady,
   output logic       CoinValid,
   output logic [2:0] CoinOut,
   output logic [1:0] Quarters,
   output logic [1:0] Dimes,
   output logic [1:0] Nickels,
   output logic [3:0] Remaining,
   output logic       Busy,
   output logic       Done,
   output logic       ExactAmmount,
   output logic       CoughUpMore,
   output logic       NotEnoughChange
);

   typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, FINISH} state_t;

   localparam logic [2:0] COIN_Q = 3'b101;
   localparam logic [2:0] COIN_D = 3'b010;
   localparam logic [2:0] COIN_N = 3'b001;

   state_t     state;
   logic [3:0] cost_r, paid_r;
   logic [2:0] coin;
   logic [3:0] rem_next;

   // Greedy pick from registered state only, so the presented coin cannot
   // change while the ejector stalls. The chosen coin never exceeds Remaining.
   always_comb begin
      coin = 3'b000;
      if (state == DISPENSE && Remaining != 4'd0) begin
         if (Remaining >= 4'd5 && Quarters != 2'd0)   coin = COIN_Q;
         else if (Remaining >= 4'd2 && Dimes != 2'd0) coin = COIN_D;
         else if (Nickels != 2'd0)                    coin = COIN_N;
      end
   end

   assign CoinOut   = coin;
   assign CoinValid = (coin != 3'b000);
   assign Busy      = (state != IDLE);
   assign rem_next  = Remaining - {1'b0, coin};

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cost_r          <= '0;
         paid_r          <= '0;
         Remaining       <= '0;
         Quarters        <= '0;
         Dimes           <= '0;
         Nickels         <= '0;
         Done            <= 1'b0;
         ExactAmmount    <= 1'b0;
         CoughUpMore     <= 1'b0;
         NotEnoughChange <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               // Restock wins over Start in the same cycle.
               if (LoadCoins) begin
                  Quarters <= LoadQuarters;
                  Dimes    <= LoadDimes;
                  Nickels  <= LoadNickels;
               end else if (Start) begin
                  cost_r          <= Cost;
                  paid_r          <= Paid;
                  ExactAmmount    <= 1'b0;
                  CoughUpMore     <= 1'b0;
                  NotEnoughChange <= 1'b0;
                  state           <= CHECK;
               end
            end
            CHECK: begin
               if ({1'b0, paid_r} < {1'b0, cost_r}) begin
                  CoughUpMore <= 1'b1;
                  Remaining   <= '0;
                  Done        <= 1'b1;
                  state       <= FINISH;
               end else if (paid_r == cost_r) begin
                  ExactAmmount <= 1'b1;
                  Remaining    <= '0;
                  Done         <= 1'b1;
                  state        <= FINISH;
               end else begin
                  Remaining <= paid_r - cost_r;
                  state     <= DISPENSE;
               end
            end
            DISPENSE: begin
               if (coin == 3'b000) begin
                  // Change still owed but nothing in the box fits; coins
                  // already handed out stay handed out.
                  NotEnoughChange <= 1'b1;
                  Done            <= 1'b1;
                  state           <= FINISH;
               end else if (CoinReady) begin
                  case (coin)
                     COIN_Q:  Quarters <= Quarters - 2'd1;
                     COIN_D:  Dimes    <= Dimes - 2'd1;
                     default: Nickels  <= Nickels - 2'd1;
                  endcase
                  Remaining <= rem_next;
                  if (rem_next == 4'd0) begin
                     Done  <= 1'b1;
                     state <= FINISH;
                  end
               end
            end
            FINISH: begin
               Done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb_change_dispense_ctrl
//   Directed steps for change_dispense_ctrl. Expected coins are queued when a
//   transaction is launched and popped by a monitor at each handshake.
module tb_change_dispense_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       Start, LoadCoins, CoinReady;
   logic [3:0] Cost, Paid;
   logic [1:0] LoadQuarters, LoadDimes, LoadNickels;
   logic       CoinValid, Busy, Done, ExactAmmount, CoughUpMore, NotEnoughChange;
   logic [2:0] CoinOut;
   logic [1:0] Quarters, Dimes, Nickels;
   logic [3:0] Remaining;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   change_dispense_ctrl dut (
      .clk(clk), .rst(rst), .Start(Start), .Cost(Cost), .Paid(Paid),
      .LoadCoins(LoadCoins), .LoadQuarters(LoadQuarters), .LoadDimes(LoadDimes),
      .LoadNickels(LoadNickels), .CoinReady(CoinReady), .CoinValid(CoinValid),
      .CoinOut(CoinOut), .Quarters(Quarters), .Dimes(Dimes), .Nickels(Nickels),
      .Remaining(Remaining), .Busy(Busy), .Done(Done), .ExactAmmount(ExactAmmount),
      .CoughUpMore(CoughUpMore), .NotEnoughChange(NotEnoughChange)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (Done) break;
      end
      check("done_seen", Done, 1);
   endtask

   task automatic check_inv(input string tag, input int q, input int d, input int n);
      check({tag, "_q"}, Quarters, q);
      check({tag, "_d"}, Dimes, d);
      check({tag, "_n"}, Nickels, n);
   endtask

   task automatic load(input logic [1:0] q, input logic [1:0] d, input logic [1:0] n);
      LoadCoins = 1'b1; LoadQuarters = q; LoadDimes = d; LoadNickels = n;
      tick();
      LoadCoins = 1'b0;
   endtask

   // Scoreboard: every accepted coin must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && CoinValid && CoinReady) begin
         check("coin_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("coin_value", CoinOut, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1; Start = 1'b0; LoadCoins = 1'b0; CoinReady = 1'b0;
      Cost = '0; Paid = '0; LoadQuarters = '0; LoadDimes = '0; LoadNickels = '0;
      tick(); tick();
      @(negedge clk);
      check("rst_busy", Busy, 0);
      check("rst_valid", CoinValid, 0);
      check("rst_done", Done, 0);
      check("rst_rem", Remaining, 0);
      check_inv("rst_inv", 0, 0, 0);
      tick();
      rst = 1'b0;

      // Owe 9 with Q=2,D=2,N=2: quarter, dime, dime.
      load(2'd2, 2'd2, 2'd2);
      check_inv("load1", 2, 2, 2);
      exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(2);
      Cost = 4'd3; Paid = 4'd12; CoinReady = 1'b1; Start = 1'b1;
      tick();
      Start = 1'b0;
      @(negedge clk);
      check("t1_busy_check", Busy, 1);
      check("t1_no_coin_in_check", CoinValid, 0);
      wait_done();
      check("t1_rem", Remaining, 0);
      check("t1_nec", NotEnoughChange, 0);
      check_inv("t1_inv", 1, 0, 2);
      check("t1_q_empty", exp_q.size(), 0);
      tick();

      // Exact payment: Done in cycle N+2, no coin.
      Cost = 4'd7; Paid = 4'd7; Start = 1'b1;
      tick();
      Start = 1'b0;
      @(negedge clk);
      check("t2_done_n1", Done, 0);
      tick();
      @(negedge clk);
      check("t2_done_n2", Done, 1);
      check("t2_exact", ExactAmmount, 1);
      check("t2_valid", CoinValid, 0);
      check("t2_rem", Remaining, 0);
      tick();
      @(negedge clk);
      check("t2_done_pulse", Done, 0);
      check("t2_exact_hold", ExactAmmount, 1);
      check("t2_idle", Busy, 0);

      // Short payment.
      tick();
      Cost = 4'd9; Paid = 4'd4; Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done();
      check("t3_cough", CoughUpMore, 1);
      check("t3_exact_cleared", ExactAmmount, 0);
      check("t3_rem", Remaining, 0);
      check_inv("t3_inv", 1, 0, 2);
      tick();

      // Owe 5 with Q=0,D=1,N=1: dime, nickel, then short by 2.
      load(2'd0, 2'd1, 2'd1);
      exp_q.push_back(2); exp_q.push_back(1);
      Cost = 4'd0; Paid = 4'd5; Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done();
      check("t4_nec", NotEnoughChange, 1);
      check("t4_rem", Remaining, 2);
      check_inv("t4_inv", 0, 0, 0);
      check("t4_q_empty", exp_q.size(), 0);
      tick();

      // Owe 2 with the ejector stalled for 4 cycles.
      load(2'd0, 2'd1, 2'd0);
      exp_q.push_back(2);
      CoinReady = 1'b0;
      Cost = 4'd1; Paid = 4'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t5_stall_valid", CoinValid, 1);
         check("t5_stall_coin", CoinOut, 3'b010);
         check("t5_stall_dimes", Dimes, 1);
         tick();
      end
      CoinReady = 1'b1;
      wait_done();
      check("t5_dimes", Dimes, 0);
      check("t5_rem", Remaining, 0);
      check("t5_q_empty", exp_q.size(), 0);
      tick();

      // Reset mid-DISPENSE; Start/LoadCoins while Busy are ignored.
      load(2'd2, 2'd0, 2'd0);
      Cost = 4'd0; Paid = 4'd15; Start = 1'b1;
      tick();
      LoadCoins = 1'b1; LoadQuarters = 2'd3; LoadDimes = 2'd3; LoadNickels = 2'd3;
      tick();
      Start = 1'b0; LoadCoins = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_inv("t6_busy_load_ignored", 2, 0, 0);
      check("t6_valid", CoinValid, 1);
      check("t6_coin", CoinOut, 3'b101);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_busy", Busy, 0);
      check("t6_valid_rst", CoinValid, 0);
      check("t6_coin_rst", CoinOut, 0);
      check("t6_done", Done, 0);
      check("t6_rem", Remaining, 0);
      check("t6_flags", {ExactAmmount, CoughUpMore, NotEnoughChange}, 0);
      check_inv("t6_inv", 0, 0, 0);
      check("final_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
